fifo_stream_drain: RTL

Downstream consumer of the team's synchronous FIFO. It pops words through the FIFO's read port and re-presents them as a valid/ready stream through a 2-entry output buffer. The buffer decouples the FIFO pop from downstream back-pressure. The block also frames the stream into fixed-length packets by asserting `o_last` on every PKT_LEN-th beat.

---
 rtl/fifo_drain_pkg.sv | 23 ++
 rtl/fifo_drain_skid.sv | 73 +++++++
 rtl/fifo_stream_drain.sv | 76 +++++++
 3 files changed

// File: rtl/fifo_drain_pkg.sv
// ============================================================================
// fifo_drain_pkg
// Shared types and helpers for the FIFO stream drain block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_drain_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } drain_state_t;

  // Beat-counter width; a single-beat packet still needs one bit.
  function automatic int bcnt_width(input int pkt_len);
    return (pkt_len > 1) ? $clog2(pkt_len) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_drain_skid.sv
// ============================================================================
// fifo_drain_skid
// Two-entry output buffer that pops a fall-through FIFO and presents a
// valid/ready stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = 19
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_fifo_data,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd_incr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  drain_state_t     r_state;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_pop;
  logic             w_hs;

  // Pop depends on registered state only, so i_ready never reaches the FIFO.
  assign w_pop          = !i_rst && !i_fifo_empty && (r_state != TWO);
  assign o_fifo_rd_incr = w_pop;
  assign o_valid        = (r_state != EMPTY);
  assign o_data         = r_head;
  assign w_hs           = o_valid && i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_pop) begin
            r_head  <= i_fifo_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_pop && !w_hs) begin
            r_tail  <= i_fifo_data;
            r_state <= TWO;
          end else if (!w_pop && w_hs) begin
            r_state <= EMPTY;
          end else if (w_pop && w_hs) begin
            r_head <= i_fifo_data;
          end
        end
        TWO: begin
          if (w_hs) begin
            r_head  <= r_tail;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_stream_drain.sv
// ============================================================================
// fifo_stream_drain
// Drains a synchronous FIFO into a packet-framed valid/ready stream.
// Optional beat statistics counter enabled by FIFO_DRAIN_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_stream_drain
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH   = 19,
  parameter int PKT_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_fifo_data,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd_incr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_last,
  output logic [31:0]      o_beat_count
);

  localparam int BCNT_W = bcnt_width(PKT_LEN);
  localparam logic [BCNT_W-1:0] c_LAST = BCNT_W'(PKT_LEN - 1);

  logic [BCNT_W-1:0] r_bcnt;
  logic              w_hs;

  fifo_drain_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_fifo_data    (i_fifo_data),
    .i_fifo_empty   (i_fifo_empty),
    .o_fifo_rd_incr (o_fifo_rd_incr),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready)
  );

  assign w_hs   = o_valid && i_ready;
  assign o_last = o_valid && (r_bcnt == c_LAST);

  // Beat position survives FIFO underflow so a packet resumes where it paused.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bcnt <= '0;
    end else if (w_hs) begin
      r_bcnt <= (r_bcnt == c_LAST) ? '0 : r_bcnt + 1'b1;
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0] r_beat_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_beat_count <= '0;
    end else if (w_hs) begin
      r_beat_count <= r_beat_count + 32'd1;
    end
  end

  assign o_beat_count = r_beat_count;
`else
  assign o_beat_count = 32'd0;
`endif

endmodule

`default_nettype wire
